debug_uart_frame_scheduler: RTL and testbench

Shares one debug UART transmitter (`debug_uart_transmitter`) among `N_REQ` on-chip requesters. It round-robin-arbitrates requests and latches the winner's payload. Each payload goes out as a framed byte stream: sync, channel ID, payload, XOR checksum. It paces the transmitter through its `i_Tx_DV` / `o_Tx_Active` / `o_Tx_Done` handshake and sits directly in front of the transmitter in the MOPS-Hub debug path.

---
 rtl/debug_uart_pkg.sv | 23 ++
 rtl/debug_rr_arbiter.sv | 42 ++++
 rtl/debug_uart_frame_scheduler.sv | 171 +++++++++++++++++
 tb/tb_debug_uart_frame_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_uart_pkg.sv
// Shared types and helpers for the debug UART frame scheduler: FSM encoding,
// default sync byte, frame length and ID byte construction.
package debug_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACT,
        ST_WAIT_DONE
    } sched_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Sync + ID + payload + checksum.
    function automatic int frame_len(input int payload_bytes);
        return payload_bytes + 3;
    endfunction

    function automatic logic [7:0] id_byte(input logic [2:0] idx);
        return {5'b0, idx};
    endfunction

endpackage

// File: rtl/debug_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// ptr, wrapping around. The pointer register lives in the caller.
module debug_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       index,
    output logic             valid
);

    logic [7:0]       req_pad;
    logic [N_REQ-1:0] hit;
    logic [2:0]       slot [N_REQ];

    assign req_pad = 8'(req);

    // slot[gi] is the requester sitting gi positions after the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slot
            logic [3:0] sum;
            assign sum      = {1'b0, ptr} + 4'(gi);
            assign slot[gi] = (sum >= 4'(N_REQ)) ? 3'(sum - 4'(N_REQ)) : sum[2:0];
            assign hit[gi]  = req_pad[slot[gi]];
        end
    endgenerate

    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                index = slot[i];
                valid = 1'b1;
            end
        end
        grant = valid ? (N_REQ'(1) << index) : '0;
    end

endmodule

// File: rtl/debug_uart_frame_scheduler.sv
// Arbitrates N_REQ requesters onto one debug UART transmitter and streams
// each winner's payload as SYNC, ID, payload (MSB first), XOR checksum.
module debug_uart_frame_scheduler
    import debug_uart_pkg::*;
#(
    parameter int         N_REQ         = 4,
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic                             i_Clock,
    input  logic                             i_Reset,
    input  logic [N_REQ-1:0]                 i_Req,
    input  logic [N_REQ*8*PAYLOAD_BYTES-1:0] i_Data,
    output logic [N_REQ-1:0]                 o_Ack,
    output logic                             o_Busy,
    output logic [2:0]                       o_Grant_Id,
    output logic                             o_Tx_DV,
    output logic [7:0]                       o_Tx_Byte,
    input  logic                             i_Tx_Active,
    input  logic                             i_Tx_Done
);

    localparam int PW        = 8 * PAYLOAD_BYTES;
    localparam int FRAME_LEN = frame_len(PAYLOAD_BYTES);
    localparam int LAST      = FRAME_LEN - 1;

    sched_state_t     state_reg, state_next;
    logic [2:0]       rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0]    shift_reg, shift_next;
    logic [4:0]       byte_idx_reg, byte_idx_next;
    logic [7:0]       chk_reg, chk_next;
    logic [N_REQ-1:0] ack_reg, ack_next;
    logic             busy_reg, busy_next;
    logic [2:0]       grant_id_reg, grant_id_next;
    logic             tx_dv_reg, tx_dv_next;
    logic [7:0]       tx_byte_reg, tx_byte_next;

    logic [N_REQ-1:0] arb_grant;
    logic [2:0]       arb_index;
    logic             arb_valid;
    logic [7:0]       frame_byte;
    logic [PW-1:0]    payload [8];

    debug_rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arbiter (
        .req  (i_Req),
        .ptr  (rr_ptr_reg),
        .grant(arb_grant),
        .index(arb_index),
        .valid(arb_valid)
    );

    // Padded to 8 entries so the 3-bit grant index always selects in range.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_payload
            if (gi < N_REQ) begin : g_used
                assign payload[gi] = i_Data[gi*PW +: PW];
            end else begin : g_unused
                assign payload[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        if (byte_idx_reg == 5'd0) begin
            frame_byte = SYNC_BYTE;
        end else if (byte_idx_reg == 5'd1) begin
            frame_byte = id_byte(grant_id_reg);
        end else if (byte_idx_reg == 5'(LAST)) begin
            frame_byte = chk_reg;
        end else begin
            frame_byte = shift_reg[PW-1 -: 8];
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            shift_reg    <= '0;
            byte_idx_reg <= '0;
            chk_reg      <= '0;
            ack_reg      <= '0;
            busy_reg     <= 1'b0;
            grant_id_reg <= '0;
            tx_dv_reg    <= 1'b0;
            tx_byte_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            shift_reg    <= shift_next;
            byte_idx_reg <= byte_idx_next;
            chk_reg      <= chk_next;
            ack_reg      <= ack_next;
            busy_reg     <= busy_next;
            grant_id_reg <= grant_id_next;
            tx_dv_reg    <= tx_dv_next;
            tx_byte_reg  <= tx_byte_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        shift_next    = shift_reg;
        byte_idx_next = byte_idx_reg;
        chk_next      = chk_reg;
        ack_next      = '0;
        busy_next     = busy_reg;
        grant_id_next = grant_id_reg;
        tx_dv_next    = 1'b0;
        tx_byte_next  = tx_byte_reg;

        case (state_reg)
            ST_IDLE: begin
                if (arb_valid) begin
                    shift_next    = payload[arb_index];
                    grant_id_next = arb_index;
                    ack_next      = arb_grant;
                    busy_next     = 1'b1;
                    byte_idx_next = '0;
                    chk_next      = '0;
                    rr_ptr_next   = (arb_index == 3'(N_REQ - 1)) ? 3'd0 : arb_index + 3'd1;
                    state_next    = ST_SEND;
                end
            end
            ST_SEND: begin
                // Holding off during done keeps DV out of the transmitter's cleanup.
                if (!i_Tx_Active && !i_Tx_Done) begin
                    tx_dv_next   = 1'b1;
                    tx_byte_next = frame_byte;
                    state_next   = ST_WAIT_ACT;
                end
            end
            ST_WAIT_ACT: begin
                if (i_Tx_Active) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    byte_idx_next = byte_idx_reg + 5'd1;
                    if (byte_idx_reg >= 5'd1 && byte_idx_reg <= 5'(LAST - 1)) begin
                        chk_next = chk_reg ^ frame_byte;
                    end
                    if (byte_idx_reg >= 5'd2 && byte_idx_reg <= 5'(LAST - 1)) begin
                        shift_next = shift_reg << 8;
                    end
                    if (byte_idx_reg == 5'(LAST)) begin
                        busy_next  = 1'b0;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_SEND;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_Ack      = ack_reg;
    assign o_Busy     = busy_reg;
    assign o_Grant_Id = grant_id_reg;
    assign o_Tx_DV    = tx_dv_reg;
    assign o_Tx_Byte  = tx_byte_reg;

endmodule

// File: tb/tb_debug_uart_frame_scheduler.sv
// Directed bench for the frame scheduler against a cycle-level transmitter
// model; expected bytes and acks are queued at stimulus time.
module tb_debug_uart_frame_scheduler;

    localparam int N_REQ = 4;
    localparam int PB    = 4;
    localparam int CPB   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_REQ-1:0]   req = '0;
    logic [127:0]       data = '0;
    logic [N_REQ-1:0]   o_Ack;
    logic               o_Busy;
    logic [2:0]         o_Grant_Id;
    logic               o_Tx_DV;
    logic [7:0]         o_Tx_Byte;
    logic               tx_active = 1'b0;
    logic               tx_done = 1'b0;
    int                 bit_cnt = 0;
    int                 done_cnt = 0;

    int                 passed = 0;
    int                 total = 0;
    int                 ack_count = 0;
    int                 dv_count = 0;
    logic [7:0]         byte_q [$];
    int                 ack_q [$];

    always #5 clk = ~clk;

    debug_uart_frame_scheduler #(
        .N_REQ(N_REQ),
        .PAYLOAD_BYTES(PB),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Req(req),
        .i_Data(data),
        .o_Ack(o_Ack),
        .o_Busy(o_Busy),
        .o_Grant_Id(o_Grant_Id),
        .o_Tx_DV(o_Tx_DV),
        .o_Tx_Byte(o_Tx_Byte),
        .i_Tx_Active(tx_active),
        .i_Tx_Done(tx_done)
    );

    // Transmitter model: active for 10*CPB cycles, then done for 2 cycles.
    always @(posedge clk) begin
        if (done_cnt != 0) begin
            done_cnt <= done_cnt - 1;
            if (done_cnt == 1) tx_done <= 1'b0;
        end
        if (tx_active) begin
            if (bit_cnt == 0) begin
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
                done_cnt  <= 2;
            end else begin
                bit_cnt <= bit_cnt - 1;
            end
        end else if (o_Tx_DV && !tx_done) begin
            tx_active <= 1'b1;
            bit_cnt   <= 10 * CPB - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        int id;
        if (|o_Ack === 1'b1) begin
            check("ack_expected", 32'(ack_q.size() > 0), 1);
            if (ack_q.size() > 0) begin
                id = ack_q.pop_front();
                check("ack_onehot", 32'(o_Ack), 32'(1 << id));
                check("grant_id", 32'(o_Grant_Id), 32'(id));
            end
            ack_count++;
            $display("ack   ack=%b grant_id=%0d", o_Ack, o_Grant_Id);
        end
        if (o_Tx_DV === 1'b1) begin
            check("dv_gating", 32'({tx_active, tx_done}), 0);
            check("dv_expected", 32'(byte_q.size() > 0), 1);
            if (byte_q.size() > 0) check("tx_byte", 32'(o_Tx_Byte), 32'(byte_q.pop_front()));
            dv_count++;
            $display("byte  0x%02h (dv #%0d)", o_Tx_Byte, dv_count);
        end
    end

    task automatic push_frame(input int id, input logic [31:0] pl, input int nbytes);
        logic [7:0] f [7];
        logic [7:0] chk;
        f[0] = 8'hA5;
        f[1] = 8'(id);
        chk  = 8'(id);
        for (int b = 0; b < PB; b++) begin
            f[2+b] = pl[31-8*b -: 8];
            chk ^= f[2+b];
        end
        f[6] = chk;
        for (int b = 0; b < nbytes; b++) byte_q.push_back(f[b]);
        ack_q.push_back(id);
    endtask

    task automatic wait_not_busy(input string tag);
        int n = 0;
        while (o_Busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(o_Busy === 1'b0), 1);
    endtask

    task automatic wait_acks(input int target, input string tag);
        int n = 0;
        while (ack_count < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ack_count >= target), 1);
    endtask

    task automatic wait_dvs(input int target, input string tag);
        int n = 0;
        while (dv_count < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(dv_count >= target), 1);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int dv_start;
        int ack_start;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(o_Ack), 0);
        check("rst_busy", 32'(o_Busy), 0);
        check("rst_grant", 32'(o_Grant_Id), 0);
        check("rst_dv", 32'(o_Tx_DV), 0);
        check("rst_byte", 32'(o_Tx_Byte), 0);
        rst = 1'b0;
        settle();

        // Single request on channel 1; CHK = 01^11^22^33^44 = 45.
        data[1*32 +: 32] = 32'h11223344;
        push_frame(1, 32'h11223344, 7);
        dv_start = dv_count;
        req = 4'b0010;
        @(negedge clk);
        check("req_to_ack", 32'(o_Ack), 32'h2);
        req = 4'b0000;
        @(negedge clk);
        check("ack_one_cycle", 32'(o_Ack), 0);
        check("ack_to_dv", 32'(o_Tx_DV), 1);
        check("busy_set", 32'(o_Busy), 1);
        wait_not_busy("single_busy_timeout");
        check("busy_falls_in_done", 32'(tx_done), 1);
        check("single_dv_count", 32'(dv_count - dv_start), 7);
        settle();

        // Payload stability plus a withdrawn request from channel 3.
        data[2*32 +: 32] = 32'hDEADBEEF;
        push_frame(2, 32'hDEADBEEF, 7);
        req = 4'b0100;
        @(negedge clk);
        check("stab_ack", 32'(o_Ack), 32'h4);
        req = 4'b0000;
        @(negedge clk);
        data[2*32 +: 32] = 32'h00000000;
        repeat (20) @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        wait_not_busy("stab_busy_timeout");
        repeat (30) @(negedge clk);
        check("withdrawn_not_served", 32'(o_Busy), 0);
        settle();

        // Reset during byte 3 of a channel-0 frame.
        data[0*32 +: 32] = 32'hCAFEF00D;
        push_frame(0, 32'hCAFEF00D, 4);
        ack_start = ack_count;
        dv_start  = dv_count;
        req = 4'b0001;
        wait_acks(ack_start + 1, "midrst_ack_timeout");
        req = 4'b0000;
        wait_dvs(dv_start + 4, "midrst_dv_timeout");
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_dv", 32'(o_Tx_DV), 0);
        check("midrst_busy", 32'(o_Busy), 0);
        check("midrst_ack", 32'(o_Ack), 0);
        check("midrst_grant", 32'(o_Grant_Id), 0);
        check("midrst_byte", 32'(o_Tx_Byte), 0);
        check("midrst_rr_ptr", 32'(dut.rr_ptr_reg), 0);
        @(negedge clk);
        rst = 1'b0;
        data[0*32 +: 32] = 32'h01020304;
        push_frame(0, 32'h01020304, 7);
        ack_start = ack_count;
        req = 4'b0001;
        wait_acks(ack_start + 1, "postrst_ack_timeout");
        req = 4'b0000;
        wait_not_busy("postrst_busy_timeout");
        settle();

        // Round-robin with every requester held: order 0,1,2,3,0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N_REQ; k++) data[k*32 +: 32] = 32'hA0B0C0D0 + 32'(k);
        push_frame(0, 32'hA0B0C0D0, 7);
        push_frame(1, 32'hA0B0C0D1, 7);
        push_frame(2, 32'hA0B0C0D2, 7);
        push_frame(3, 32'hA0B0C0D3, 7);
        push_frame(0, 32'hA0B0C0D0, 7);
        ack_start = ack_count;
        req = 4'b1111;
        wait_acks(ack_start + 5, "rr_ack_timeout");
        req = 4'b0000;
        wait_not_busy("rr_busy_timeout");
        repeat (30) @(negedge clk);

        check("final_byte_queue_empty", 32'(byte_q.size()), 0);
        check("final_ack_queue_empty", 32'(ack_q.size()), 0);
        check("final_dv_total", 32'(dv_count), 60);
        check("final_ack_total", 32'(ack_count), 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
